// File: rtl/fab_cfg_pkg.sv
// Shared types and defaults for the eFPGA fabric bit-bang configuration master.
package fab_cfg_pkg;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    typedef enum logic [1:0] {
        PH_DATA,
        PH_CLK_HI,
        PH_CTRL,
        PH_CLK_LO
    } phase_t;

    localparam logic [31:0] FAB_CTRL_WORD = 32'h0000FAB1;

endpackage

// File: rtl/fab_phase_timer.sv
// Quarter-bit prescaler: emits a one-cycle tick every PHASE_CYCLES enabled cycles.
module fab_phase_timer #(
    parameter int PHASE_CYCLES = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tick
);

    localparam int CW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(PHASE_CYCLES - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
        end
    end

    assign o_tick = i_enable && (r_count == LAST);

endmodule

// File: rtl/fab_bitbang_driver.sv
// Serialises stream words MSB-first onto per-channel s_clk/s_data pins,
// interleaving each data bit with one bit of a fixed control word.
module fab_bitbang_driver
    import fab_cfg_pkg::*;
#(
    parameter int                DATA_W       = 32,
    parameter logic [DATA_W-1:0] CTRL_WORD    = DATA_W'(FAB_CTRL_WORD),
    parameter int                PHASE_CYCLES = 1,
    parameter int                NUM_CH       = 1,
    parameter int                CNT_W        = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0] in_mask,
    input  logic              in_last,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [NUM_CH-1:0] s_clk,
    output logic [NUM_CH-1:0] s_data,
    output logic              busy,
    output logic              word_done,
    output logic              frame_done,
    output logic [CNT_W-1:0]  words_sent
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_W - 1);

    state_t            r_state;
    state_t            w_state_nx;
    phase_t            r_phase;
    logic [DATA_W-1:0] r_word;
    logic [DATA_W-1:0] r_ctrl;
    logic [DATA_W-1:0] w_word_shl;
    logic [NUM_CH-1:0] r_mask;
    logic [NUM_CH-1:0] r_s_clk;
    logic [NUM_CH-1:0] r_s_data;
    logic [IDX_W-1:0]  r_bit_idx;
    logic [CNT_W-1:0]  r_words_sent;
    logic              r_last;
    logic              r_in_ready;
    logic              r_busy;
    logic              r_word_done;
    logic              r_frame_done;
    logic              w_tick;
    logic              w_accept;
    logic              w_word_end;

    fab_phase_timer #(
        .PHASE_CYCLES(PHASE_CYCLES)
    ) u_phase_timer (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_clear (w_accept),
        .i_enable(r_state == SHIFT),
        .o_tick  (w_tick)
    );

    assign w_word_shl = r_word << 1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        w_word_end = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_accept   = 1'b1;
                    w_state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (w_tick && (r_phase == PH_CLK_LO) && (r_bit_idx == LAST_BIT)) begin
                    w_word_end = 1'b1;
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // Data and ctrl words are kept as shift registers so the pin always takes bit DATA_W-1.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_phase      <= PH_DATA;
            r_word       <= '0;
            r_ctrl       <= '0;
            r_mask       <= '0;
            r_last       <= 1'b0;
            r_bit_idx    <= '0;
            r_s_clk      <= '0;
            r_s_data     <= '0;
            r_in_ready   <= 1'b0;
            r_busy       <= 1'b0;
            r_word_done  <= 1'b0;
            r_frame_done <= 1'b0;
            r_words_sent <= '0;
        end else begin
            r_in_ready   <= (w_state_nx == IDLE);
            r_busy       <= (w_state_nx != IDLE);
            r_word_done  <= w_word_end;
            r_frame_done <= w_word_end && r_last;
            if (w_word_end && (r_words_sent != '1)) begin
                r_words_sent <= r_words_sent + 1'b1;
            end

            if (w_accept) begin
                r_word    <= in_data;
                r_ctrl    <= CTRL_WORD;
                r_mask    <= in_mask;
                r_last    <= in_last;
                r_bit_idx <= '0;
                r_phase   <= PH_DATA;
                r_s_clk   <= '0;
                r_s_data  <= {NUM_CH{in_data[DATA_W-1]}} & in_mask;
            end else if ((r_state == SHIFT) && w_tick) begin
                case (r_phase)
                    PH_DATA: begin
                        r_phase <= PH_CLK_HI;
                        r_s_clk <= r_mask;
                    end
                    PH_CLK_HI: begin
                        r_phase  <= PH_CTRL;
                        r_s_data <= {NUM_CH{r_ctrl[DATA_W-1]}} & r_mask;
                    end
                    PH_CTRL: begin
                        r_phase <= PH_CLK_LO;
                        r_s_clk <= '0;
                    end
                    default: begin
                        r_phase <= PH_DATA;
                        // On the final bit s_data keeps the last ctrl bit through IDLE.
                        if (!w_word_end) begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_word    <= w_word_shl;
                            r_ctrl    <= r_ctrl << 1;
                            r_s_data  <= {NUM_CH{w_word_shl[DATA_W-1]}} & r_mask;
                        end
                    end
                endcase
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign busy       = r_busy;
    assign word_done  = r_word_done;
    assign frame_done = r_frame_done;
    assign s_clk      = r_s_clk;
    assign s_data     = r_s_data;
    assign words_sent = r_words_sent;

endmodule

// File: tb/tb_fab_bitbang_driver.sv
// Randomised bench: a negedge monitor rebuilds each word from pin edges and compares it
// with the accepted word, its timing and the saturating word count.
module tb_fab_bitbang_driver;

    localparam int D        = 8;
    localparam int P        = 3;
    localparam int NC       = 4;
    localparam int CW       = 3;
    localparam int WORD_CYC = 4 * P * D;
    localparam int MAXC     = (1 << CW) - 1;
    localparam logic [D-1:0] CTRL = 8'hB1;

    logic          CLK;
    logic          RST;
    logic [D-1:0]  in_data;
    logic [NC-1:0] in_mask;
    logic          in_last;
    logic          in_valid;
    logic          in_ready;
    logic [NC-1:0] s_clk;
    logic [NC-1:0] s_data;
    logic          busy;
    logic          word_done;
    logic          frame_done;
    logic [CW-1:0] words_sent;

    fab_bitbang_driver #(
        .DATA_W      (D),
        .CTRL_WORD   (CTRL),
        .PHASE_CYCLES(P),
        .NUM_CH      (NC),
        .CNT_W       (CW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_data   (in_data),
        .in_mask   (in_mask),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s_clk     (s_clk),
        .s_data    (s_data),
        .busy      (busy),
        .word_done (word_done),
        .frame_done(frame_done),
        .words_sent(words_sent)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int            k;
        logic [D-1:0]  data;
        logic [NC-1:0] mask;
        logic          last;
    } word_t;

    word_t exp_q[$];
    int    hs_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc = 0;
    int    completed = 0;
    bit    in_reset = 1'b1;

    logic [NC-1:0] prev_clk = '0;
    logic [NC-1:0] prev_data = '0;
    logic [D-1:0]  rise_bits [NC];
    logic [D-1:0]  fall_bits [NC];
    int            rise_cnt [NC];
    int            fall_cnt [NC];
    int            first_rise, first_fall, unsel_bad, coincide_bad, status_bad;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge CLK) cyc = cyc + 1;

    // Monitor: after edge number cyc, observe pins and handshakes.
    always @(negedge CLK) begin
        if (!in_reset && exp_q.size() > 0 && cyc >= exp_q[0].k) begin
            for (int ch = 0; ch < NC; ch++) begin
                if (!exp_q[0].mask[ch]) begin
                    if (s_clk[ch] || s_data[ch]) unsel_bad++;
                end else begin
                    if (s_clk[ch] && !prev_clk[ch]) begin
                        rise_bits[ch] = {rise_bits[ch][D-2:0], s_data[ch]};
                        rise_cnt[ch]++;
                        if (first_rise < 0) first_rise = cyc;
                    end
                    if (!s_clk[ch] && prev_clk[ch]) begin
                        fall_bits[ch] = {fall_bits[ch][D-2:0], s_data[ch]};
                        fall_cnt[ch]++;
                        if (first_fall < 0) first_fall = cyc;
                    end
                end
                if ((s_clk[ch] != prev_clk[ch]) && (s_data[ch] != prev_data[ch])) coincide_bad++;
            end
            if (cyc < exp_q[0].k + WORD_CYC && (!busy || in_ready)) status_bad++;
        end

        if (!in_reset && word_done) begin
            if (exp_q.size() == 0) begin
                check("spurious_word_done", 1, 0);
            end else begin
                word_t e;
                e = exp_q.pop_front();
                completed++;
                check("done_cycle", cyc, e.k + WORD_CYC);
                check("frame_done", frame_done, e.last);
                check("first_rise", first_rise, (e.mask != 0) ? e.k + P : -1);
                check("first_fall", first_fall, (e.mask != 0) ? e.k + 3 * P : -1);
                for (int ch = 0; ch < NC; ch++) begin
                    check($sformatf("rise_cnt%0d", ch), rise_cnt[ch], e.mask[ch] ? D : 0);
                    check($sformatf("fall_cnt%0d", ch), fall_cnt[ch], e.mask[ch] ? D : 0);
                    check($sformatf("data_bits%0d", ch), rise_bits[ch], e.mask[ch] ? e.data : '0);
                    check($sformatf("ctrl_bits%0d", ch), fall_bits[ch], e.mask[ch] ? CTRL : '0);
                end
                check("unselected_quiet", unsel_bad, 0);
                check("data_vs_clk_edge", coincide_bad, 0);
                check("busy_during_word", status_bad, 0);
                check("idle_ready", {in_ready, busy}, 2'b10);
                check("idle_s_clk", s_clk, '0);
                check("idle_s_data", s_data, e.mask & {NC{CTRL[0]}});
                check("words_sent", words_sent, (completed > MAXC) ? MAXC : completed);
            end
        end else if (!in_reset && frame_done) begin
            check("frame_without_word", 1, 0);
        end

        if (!in_reset && in_valid && in_ready) begin
            word_t n;
            n.k    = cyc + 1;
            n.data = in_data;
            n.mask = in_mask;
            n.last = in_last;
            exp_q.push_back(n);
            hs_q.push_back(n.k);
            for (int ch = 0; ch < NC; ch++) begin
                rise_bits[ch] = '0;
                fall_bits[ch] = '0;
                rise_cnt[ch]  = 0;
                fall_cnt[ch]  = 0;
            end
            first_rise   = -1;
            first_fall   = -1;
            unsel_bad    = 0;
            coincide_bad = 0;
            status_bad   = 0;
        end

        prev_clk  = s_clk;
        prev_data = s_data;
    end

    // Presents a word and returns 2 time units after the accepting edge.
    task automatic drive_word(input logic [D-1:0] d, input logic [NC-1:0] m,
                              input logic l, input bit hold);
        bit accepted = 1'b0;
        bit ready;
        in_data  = d;
        in_mask  = m;
        in_last  = l;
        in_valid = 1'b1;
        for (int t = 0; t < 3 * WORD_CYC && !accepted; t++) begin
            @(negedge CLK);
            ready = in_ready;
            @(posedge CLK);
            #2;
            if (ready) accepted = 1'b1;
        end
        if (!accepted) check("accept_timeout", 0, 1);
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int t = 0; t < 4 * WORD_CYC && !done; t++) begin
            @(negedge CLK);
            if (exp_q.size() == 0) done = 1'b1;
        end
        if (!done) check("drain_timeout", 0, 1);
        @(posedge CLK);
        #2;
    endtask

    initial begin
        int n0;
        RST      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_mask  = '0;
        in_last  = 1'b0;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_ready", in_ready, 0);
        check("rst_pins", {s_clk, s_data}, '0);
        check("rst_status", {busy, word_done, frame_done}, 3'b000);
        check("rst_count", words_sent, 0);
        RST = 1'b0;
        @(negedge CLK);
        check("ready_after_rst", in_ready, 1);
        in_reset = 1'b0;
        @(posedge CLK);
        #2;

        // Reset in the middle of bit 5.
        drive_word(D'($urandom), 4'b1111, 1'b0, 1'b0);
        repeat (4 * P * 5 + 1) @(posedge CLK);
        #2;
        in_reset = 1'b1;
        RST      = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        check("midrst_pins", {s_clk, s_data}, '0);
        check("midrst_status", {in_ready, busy, word_done}, 3'b000);
        exp_q.delete();
        completed = 0;
        RST = 1'b0;
        @(negedge CLK);
        check("midrst_ready", {in_ready, busy}, 2'b10);
        check("midrst_count", words_sent, 0);
        in_reset = 1'b0;
        @(posedge CLK);
        #2;

        drive_word(8'h81, 4'b0001, 1'b1, 1'b0);
        wait_idle();

        drive_word(D'($urandom), 4'b0101, 1'b0, 1'b0);
        wait_idle();
        drive_word(D'($urandom), 4'b0000, 1'b1, 1'b0);
        wait_idle();
        check("count_after_masks", words_sent, 3);

        n0 = hs_q.size();
        drive_word(D'($urandom), NC'($urandom), 1'b0, 1'b1);
        drive_word(D'($urandom), NC'($urandom), 1'b0, 1'b1);
        drive_word(D'($urandom), NC'($urandom), 1'b1, 1'b0);
        wait_idle();
        check("held_hs_count", hs_q.size() - n0, 3);
        if (hs_q.size() == n0 + 3) begin
            check("held_gap1", hs_q[n0 + 1] - hs_q[n0], WORD_CYC + 1);
            check("held_gap2", hs_q[n0 + 2] - hs_q[n0 + 1], WORD_CYC + 1);
        end

        for (int i = 0; i < 6; i++) begin
            drive_word(D'($urandom), NC'($urandom), 1'($urandom_range(0, 1)),
                       (i < 5) ? bit'($urandom_range(0, 1)) : 1'b0);
            if (!in_valid) repeat ($urandom_range(0, 5)) @(posedge CLK);
            #2;
        end
        wait_idle();
        check("count_saturated", words_sent, MAXC);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fab_bitbang_driver.md
# fab_bitbang_driver

Synthesizable bit-bang configuration master for eFPGA fabrics. It accepts bitstream words on a valid/ready stream and serialises each one MSB-first onto the `s_clk`/`s_data` configuration pins of one or more fabrics. Every data bit is interleaved with a bit of a fixed control word. It replaces testbench-only bit-banging so that on-chip loaders, such as a UART or SPI flash reader, can program the fabric. It generalises that bit-banging in word width, phase duration, channel count and per-word channel masking.

## Interface
Parameters:
- `DATA_W`, 32: word width; bits shifted per word; must be ≥1.
- `CTRL_WORD`, 32'h0000FAB1: control word, `DATA_W` bits, sent interleaved with the data; bit `DATA_W-1` first.
- `PHASE_CYCLES`, 1: CLK cycles per quarter-bit phase; must be ≥1.
- `NUM_CH`, 1: number of independent `s_clk`/`s_data` pin pairs.
- `CNT_W`, 16: width of the words-sent counter.

Ports:
- `CLK` in 1: clock; all logic rises on the posedge.
- `RST` in 1: reset, synchronous, active-high.
- `in_data` in `DATA_W`: bitstream word.
- `in_mask` in `NUM_CH`: channels that receive this word; bit i selects channel i.
- `in_last` in 1: marks the final word of a frame.
- `in_valid` in 1: word present.
- `in_ready` out 1: driver can accept a word; high only in IDLE.
- `s_clk` out `NUM_CH`: configuration clock per channel.
- `s_data` out `NUM_CH`: configuration data per channel.
- `busy` out 1: high in any state other than IDLE.
- `word_done` out 1: one-cycle pulse when a word's serialisation completes.
- `frame_done` out 1: one-cycle pulse together with `word_done` when the completed word had `in_last` set.
- `words_sent` out `CNT_W`: count of completed words; saturates at all-ones; cleared only by `RST`.

## Operation
- Reset values: `in_ready`=0 during `RST` and 1 afterwards. `s_clk`, `s_data`, `busy`, `word_done`, `frame_done` and `words_sent` all reset to 0. State resets to IDLE.
- States:
  - IDLE:
    - `in_ready`=1.
    - A handshake (`in_valid && in_ready` at a posedge) latches `in_data`, `in_mask` and `in_last`, clears the bit index and phase counter, and moves to SHIFT.
  - SHIFT:
    - 4 phases per bit, each `PHASE_CYCLES` long:
      - ph0: `s_data`=data bit.
      - ph1: `s_clk`=1.
      - ph2: `s_data`=ctrl bit.
      - ph3: `s_clk`=0.
    - Bit i sends `in_data[DATA_W-1-i]` and `CTRL_WORD[DATA_W-1-i]`.
    - After ph3 of bit `DATA_W-1` expires, go to IDLE. In that same cycle:
      - pulse `word_done`;
      - pulse `frame_done` if the latched `in_last` was set;
      - increment `words_sent`.
- Masking:
  - Only channels whose latched mask bit is 1 toggle.
  - Unselected channels hold `s_clk`=0 and `s_data`=0.
  - A word with mask=0 still occupies the full SHIFT duration and is counted, but no pin toggles.
- In IDLE, all `s_clk`=0. `s_data` holds its last value: the final ctrl bit on selected channels, 0 elsewhere.
- `in_valid` is ignored while busy. An upstream source may hold `in_valid` high; words are never dropped or duplicated.
- Reset mid-word: all pins go to 0 at the reset edge and the latched word is discarded.

## Timing
- Handshake at edge k (k is the accepting posedge):
  - `s_data`=data MSB is visible after k.
  - `s_clk` rises at k+P.
  - ctrl MSB appears at k+2P.
  - `s_clk` falls at k+3P.
  - The next data bit appears at k+4P.
  - Here P = `PHASE_CYCLES`.
- `s_data` never changes in the same cycle as an `s_clk` edge: it is stable P cycles before and after each rising edge.
- IDLE is re-entered at edge k+4·P·`DATA_W`. `word_done`, `frame_done` and `in_ready` are high in the following cycle.
- The earliest next handshake is edge k+4·P·`DATA_W`+1, so the word period is 4·P·`DATA_W`+1 cycles.
- All outputs are registered; there is no combinational path from inputs to pins.

## Structure
- Package `fab_cfg_pkg` holds:
  - the state enum (IDLE, SHIFT);
  - the phase enum (PH_DATA, PH_CLK_HI, PH_CTRL, PH_CLK_LO);
  - the default `FAB_CTRL_WORD` = 32'h0000FAB1.
- Sub-module `fab_phase_timer`:
  - a prescaler counting `PHASE_CYCLES`;
  - emits a one-cycle `tick` at each phase end;
  - cleared on handshake.
- The top level holds the state machine, bit index (`$clog2(DATA_W)` bits), latched word, mask, pin registers and counter.

## Test plan
- Default parameters, one word 32'hA5A5_0001 with `in_last`=1 and mask=1. Required response:
  - 32 `s_clk` pulses.
  - `s_data` sampled at each rising `s_clk` reproduces 32'hA5A5_0001.
  - `s_data` sampled at each falling `s_clk` reproduces 32'h0000FAB1.
  - `word_done` and `frame_done` pulse exactly at cycle k+129.
  - `words_sent`=1.
- `PHASE_CYCLES`=3, `DATA_W`=8, word 8'h81:
  - `s_clk` rises at k+3 and falls at k+9;
  - word period is 97 cycles.
- `NUM_CH`=4, masks 4'b0101 then 4'b0000:
  - channels 1 and 3 never toggle;
  - the second word produces no pin activity and still lasts 129 cycles;
  - `words_sent`=2.
- `in_valid` held high for 3 words, last with `in_last`:
  - handshakes land exactly 129 cycles apart;
  - `frame_done` pulses only once, after word 3.
- `RST` asserted at bit 10 of a word:
  - all pins are 0 the next cycle;
  - `in_ready`=1 after release;
  - `words_sent`=0;
  - a new word then serialises cleanly.
- `CNT_W`=2, 5 words: `words_sent` saturates at 3.
